// File: rtl/ip_hash_table.sv
// ip_hash_table: set-associative IP address table with lookup, insert,
// delete and flush, a valid/ready request handshake and a one-cycle result
// strobe. The table takes one request at a time.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   op_val, op_ready  request handshake; op_ready is high only in IDLE
//   op_code           00 lookup, 01 insert, 10 delete, 11 flush
//   ip_addr           request key (ignored for flush)
//   found_ip_valid    one-cycle result strobe
//   found_ip          hit / key-present result
//   evicted           insert displaced an entry
//   evicted_ip        key that was displaced
//   entry_count       number of valid entries in the table
//
// Optional build macro IP_HASH_STATS_EN adds the saturating 32-bit counters
// stat_lookups, stat_hits and stat_evictions (cleared only by rst).
module ip_hash_table #(
    parameter int IP_ADDR_W = 32,
    parameter int NUM_SETS  = 16,
    parameter int NUM_WAYS  = 2,
    localparam int SET_W    = $clog2(NUM_SETS),
    localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int CNT_W    = $clog2(NUM_SETS * NUM_WAYS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_val,
    input  logic [1:0]           op_code,
    input  logic [IP_ADDR_W-1:0] ip_addr,
    output logic                 op_ready,
    output logic                 found_ip_valid,
    output logic                 found_ip,
    output logic                 evicted,
    output logic [IP_ADDR_W-1:0] evicted_ip,
    output logic [CNT_W-1:0]     entry_count
`ifdef IP_HASH_STATS_EN
    ,
    output logic [31:0]          stat_lookups,
    output logic [31:0]          stat_hits,
    output logic [31:0]          stat_evictions
`endif
);

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;
    localparam logic [1:0] OP_FLUSH  = 2'b11;

    typedef enum logic [1:0] {IDLE, CHECK, FLUSH, RESP} state_t;

    // XOR-fold the key into SET_W-bit chunks from bit 0 upward; a partial
    // top chunk simply contributes to the low bits (zero extension).
    function automatic logic [SET_W-1:0] hash_key(input logic [IP_ADDR_W-1:0] key);
        logic [SET_W-1:0] h;
        h = '0;
        for (int i = 0; i < IP_ADDR_W; i++) begin
            h[i % SET_W] = h[i % SET_W] ^ key[i];
        end
        return h;
    endfunction

    function automatic logic [WAY_W-1:0] rr_next(input logic [WAY_W-1:0] p);
        if (p == WAY_W'(NUM_WAYS - 1)) begin
            return '0;
        end
        return p + WAY_W'(1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t                 state_q, state_d;
    logic                   op_ready_q, op_ready_d;
    logic [1:0]             opc_q, opc_d;
    logic [IP_ADDR_W-1:0]   key_q, key_d;
    logic [SET_W-1:0]       flush_idx_q, flush_idx_d;
    logic [NUM_WAYS-1:0]    valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]    valid_d [NUM_SETS];
    logic [WAY_W-1:0]       rr_q [NUM_SETS];
    logic [WAY_W-1:0]       rr_d [NUM_SETS];
    logic [IP_ADDR_W-1:0]   tag_q [NUM_SETS][NUM_WAYS];
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   found_valid_q, found_valid_d;
    logic                   found_q, found_d;
    logic                   evicted_q, evicted_d;
    logic [IP_ADDR_W-1:0]   evicted_ip_q, evicted_ip_d;

    logic                   tag_we;
    logic [WAY_W-1:0]       tag_way;
    logic [SET_W-1:0]       set_idx;
    logic                   hit, free;
    logic [WAY_W-1:0]       hit_way, free_way;

    assign set_idx = hash_key(key_q);

    // Way search for the latched key: matching way and lowest free way.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        free     = 1'b0;
        free_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[set_idx][w] && (tag_q[set_idx][w] == key_q) && !hit) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[set_idx][w] && !free) begin
                free     = 1'b1;
                free_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        op_ready_d    = op_ready_q;
        opc_d         = opc_q;
        key_d         = key_q;
        flush_idx_d   = flush_idx_q;
        valid_d       = valid_q;
        rr_d          = rr_q;
        count_d       = count_q;
        found_valid_d = 1'b0;
        found_d       = found_q;
        evicted_d     = evicted_q;
        evicted_ip_d  = evicted_ip_q;
        tag_we        = 1'b0;
        tag_way       = '0;

        case (state_q)
            IDLE: begin
                if (op_val && op_ready_q) begin
                    opc_d       = op_code;
                    key_d       = ip_addr;
                    op_ready_d  = 1'b0;
                    flush_idx_d = '0;
                    state_d     = (op_code == OP_FLUSH) ? FLUSH : CHECK;
                end
            end
            CHECK: begin
                evicted_d = 1'b0;
                case (opc_q)
                    OP_LOOKUP: found_d = hit;
                    OP_INSERT: begin
                        found_d = hit;
                        if (!hit) begin
                            tag_we = 1'b1;
                            if (free) begin
                                tag_way                    = free_way;
                                valid_d[set_idx][free_way] = 1'b1;
                                count_d                    = count_q + CNT_W'(1);
                            end else begin
                                tag_way       = rr_q[set_idx];
                                evicted_d     = 1'b1;
                                evicted_ip_d  = tag_q[set_idx][rr_q[set_idx]];
                                rr_d[set_idx] = rr_next(rr_q[set_idx]);
                            end
                        end
                    end
                    OP_DELETE: begin
                        found_d = hit;
                        if (hit) begin
                            valid_d[set_idx][hit_way] = 1'b0;
                            count_d                   = count_q - CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
                found_valid_d = 1'b1;
                state_d       = RESP;
            end
            FLUSH: begin
                // One set cleared per cycle, walking set 0 upward.
                valid_d[flush_idx_q] = '0;
                rr_d[flush_idx_q]    = '0;
                if (flush_idx_q == SET_W'(NUM_SETS - 1)) begin
                    count_d       = '0;
                    found_d       = 1'b0;
                    evicted_d     = 1'b0;
                    found_valid_d = 1'b1;
                    state_d       = RESP;
                end else begin
                    flush_idx_d = flush_idx_q + SET_W'(1);
                end
            end
            RESP: begin
                op_ready_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            op_ready_q    <= 1'b1;
            opc_q         <= OP_LOOKUP;
            key_q         <= '0;
            flush_idx_q   <= '0;
            count_q       <= '0;
            found_valid_q <= 1'b0;
            found_q       <= 1'b0;
            evicted_q     <= 1'b0;
            evicted_ip_q  <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q       <= state_d;
            op_ready_q    <= op_ready_d;
            opc_q         <= opc_d;
            key_q         <= key_d;
            flush_idx_q   <= flush_idx_d;
            count_q       <= count_d;
            found_valid_q <= found_valid_d;
            found_q       <= found_d;
            evicted_q     <= evicted_d;
            evicted_ip_q  <= evicted_ip_d;
            valid_q       <= valid_d;
            rr_q          <= rr_d;
        end
    end

    // Key storage carries no reset; entries are qualified by valid_q.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[set_idx][tag_way] <= key_q;
        end
    end

    assign op_ready       = op_ready_q;
    assign found_ip_valid = found_valid_q;
    assign found_ip       = found_q;
    assign evicted        = evicted_q;
    assign evicted_ip     = evicted_ip_q;
    assign entry_count    = count_q;

`ifdef IP_HASH_STATS_EN
    logic [31:0] stat_lookups_q, stat_lookups_d;
    logic [31:0] stat_hits_q, stat_hits_d;
    logic [31:0] stat_evictions_q, stat_evictions_d;

    always_comb begin
        stat_lookups_d   = stat_lookups_q;
        stat_hits_d      = stat_hits_q;
        stat_evictions_d = stat_evictions_q;
        if (state_q == CHECK) begin
            if (opc_q == OP_LOOKUP) begin
                stat_lookups_d = sat_inc(stat_lookups_q);
                if (hit) begin
                    stat_hits_d = sat_inc(stat_hits_q);
                end
            end
            if ((opc_q == OP_INSERT) && !hit && !free) begin
                stat_evictions_d = sat_inc(stat_evictions_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lookups_q   <= '0;
            stat_hits_q      <= '0;
            stat_evictions_q <= '0;
        end else begin
            stat_lookups_q   <= stat_lookups_d;
            stat_hits_q      <= stat_hits_d;
            stat_evictions_q <= stat_evictions_d;
        end
    end

    assign stat_lookups   = stat_lookups_q;
    assign stat_hits      = stat_hits_q;
    assign stat_evictions = stat_evictions_q;
`endif

endmodule

// File: tb/tb_ip_hash_table.sv
// Scoreboard bench for ip_hash_table (32-bit keys, 16 sets, 2 ways).
// The driver pushes the hand-computed result of each request; the monitor
// pops and compares on every result strobe.
module tb_ip_hash_table;

    localparam int CNT_W = $clog2(16 * 2 + 1);

    logic             clk;
    logic             rst;
    logic             op_val;
    logic [1:0]       op_code;
    logic [31:0]      ip_addr;
    logic             op_ready;
    logic             found_ip_valid;
    logic             found_ip;
    logic             evicted;
    logic [31:0]      evicted_ip;
    logic [CNT_W-1:0] entry_count;
`ifdef IP_HASH_STATS_EN
    logic [31:0]      stat_lookups;
    logic [31:0]      stat_hits;
    logic [31:0]      stat_evictions;
`endif

    ip_hash_table #(
        .IP_ADDR_W(32),
        .NUM_SETS (16),
        .NUM_WAYS (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .op_val        (op_val),
        .op_code       (op_code),
        .ip_addr       (ip_addr),
        .op_ready      (op_ready),
        .found_ip_valid(found_ip_valid),
        .found_ip      (found_ip),
        .evicted       (evicted),
        .evicted_ip    (evicted_ip),
        .entry_count   (entry_count)
`ifdef IP_HASH_STATS_EN
        ,
        .stat_lookups  (stat_lookups),
        .stat_hits     (stat_hits),
        .stat_evictions(stat_evictions)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        found;
        logic        ev;
        logic [31:0] ev_ip;
        int          cnt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_lk = 0;
    int   exp_hit = 0;
    int   exp_ev = 0;

    localparam logic [1:0] LK = 2'b00, INS = 2'b01, DEL = 2'b10, FL = 2'b11;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && found_ip_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_found", {31'd0, found_ip}, {31'd0, e.found});
                chk("mon_evicted", {31'd0, evicted}, {31'd0, e.ev});
                if (e.ev) chk("mon_evicted_ip", evicted_ip, e.ev_ip);
                chk("mon_entry_count", 32'(entry_count), 32'(e.cnt));
            end
        end
    end

    // Issue one request and wait (bounded) for its strobe, checking the
    // handshake and latency along the way.
    task automatic issue(input string name, input logic [1:0] op, input logic [31:0] addr,
                         input logic f, input logic e, input logic [31:0] eip, input int cnt);
        int w;
        int lat;
        w = 0;
        @(negedge clk);
        while (!op_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({name, "_ready"}, {31'd0, op_ready}, 32'd1);
        op_val  = 1'b1;
        op_code = op;
        ip_addr = addr;
        sb.push_back('{f, e, eip, cnt});
        if (op == LK) begin
            exp_lk++;
            if (f) exp_hit++;
        end
        if (op == INS && e) exp_ev++;
        @(posedge clk);
        #1;
        op_val  = 1'b0;
        ip_addr = 32'hDEAD_BEEF;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat <= 2) chk({name, "_busy"}, {31'd0, op_ready}, 32'd0);
        end while (!found_ip_valid && lat < 40);
        chk({name, "_latency"}, 32'(lat), (op == FL) ? 32'd17 : 32'd2);
    endtask

    initial begin
        rst     = 1'b1;
        op_val  = 1'b0;
        op_code = 2'b00;
        ip_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_op_ready", {31'd0, op_ready}, 32'd1);
        chk("rst_found_valid", {31'd0, found_ip_valid}, 32'd0);
        chk("rst_found", {31'd0, found_ip}, 32'd0);
        chk("rst_evicted", {31'd0, evicted}, 32'd0);
        chk("rst_evicted_ip", evicted_ip, 32'd0);
        chk("rst_count", 32'(entry_count), 32'd0);

        // All set-15 keys except 0x0A000001 (set 11).
        issue("ins_a",      INS, 32'hC0A8_0001, 1'b0, 1'b0, 32'd0, 1);
        issue("lk_a_hit",   LK,  32'hC0A8_0001, 1'b1, 1'b0, 32'd0, 1);
        issue("lk_miss",    LK,  32'h0A00_0001, 1'b0, 1'b0, 32'd0, 1);
        issue("reins_a",    INS, 32'hC0A8_0001, 1'b1, 1'b0, 32'd0, 1);
        issue("ins_f",      INS, 32'h0000_000F, 1'b0, 1'b0, 32'd0, 2);
        issue("ins_f0_ev",  INS, 32'h0000_00F0, 1'b0, 1'b1, 32'hC0A8_0001, 2);
        issue("lk_a_gone",  LK,  32'hC0A8_0001, 1'b0, 1'b0, 32'd0, 2);
        issue("del_f",      DEL, 32'h0000_000F, 1'b1, 1'b0, 32'd0, 1);
        issue("del_f_again",DEL, 32'h0000_000F, 1'b0, 1'b0, 32'd0, 1);
        issue("ins_f00",    INS, 32'h0000_0F00, 1'b0, 1'b0, 32'd0, 2);
        // Pointer advanced to way 1 after the first eviction.
        issue("ins_f000_ev",INS, 32'h0000_F000, 1'b0, 1'b1, 32'h0000_0F00, 2);
        issue("lk_f0_hit",  LK,  32'h0000_00F0, 1'b1, 1'b0, 32'd0, 2);
        issue("flush",      FL,  32'h0000_0000, 1'b0, 1'b0, 32'd0, 0);
        issue("lk_f0_fl",   LK,  32'h0000_00F0, 1'b0, 1'b0, 32'd0, 0);
        issue("lk_f000_fl", LK,  32'h0000_F000, 1'b0, 1'b0, 32'd0, 0);
        issue("ins_a2",     INS, 32'hC0A8_0001, 1'b0, 1'b0, 32'd0, 1);
        issue("ins_f2",     INS, 32'h0000_000F, 1'b0, 1'b0, 32'd0, 2);
`ifdef IP_HASH_STATS_EN
        chk("stat_lookups", stat_lookups, 32'(exp_lk));
        chk("stat_hits", stat_hits, 32'(exp_hit));
        chk("stat_evictions", stat_evictions, 32'(exp_ev));
`endif

        // Flush aborted by reset at cycle T+5: no strobe is expected.
        @(negedge clk);
        chk("abort_ready", {31'd0, op_ready}, 32'd1);
        op_val  = 1'b1;
        op_code = FL;
        @(posedge clk);
        #1;
        op_val = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_busy", {31'd0, op_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_op_ready", {31'd0, op_ready}, 32'd1);
        chk("abort_count", 32'(entry_count), 32'd0);
        chk("abort_no_strobe", {31'd0, found_ip_valid}, 32'd0);
`ifdef IP_HASH_STATS_EN
        chk("abort_stat_lookups", stat_lookups, 32'd0);
        chk("abort_stat_hits", stat_hits, 32'd0);
        chk("abort_stat_evictions", stat_evictions, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        issue("lk_a_after_rst", LK, 32'hC0A8_0001, 1'b0, 1'b0, 32'd0, 0);

        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
